// File: rtl/led_bank.sv
// Memory-mapped multi-channel LED controller: per-channel static, blink, PWM or forced-off modes,
// with a shared blink timebase and a shared free-running PWM counter.
module led_bank #(
  parameter int NUM_LEDS = 4,
  parameter int PERIOD_W = 24,
  parameter int PWM_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          address,
  input  logic                write_en,
  input  logic                read_en,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  output logic [NUM_LEDS-1:0] led
);

  logic [NUM_LEDS-1:0]   r_static;
  logic [2*NUM_LEDS-1:0] r_mode;
  logic [PERIOD_W-1:0]   r_period;
  logic [PWM_W-1:0]      r_duty [NUM_LEDS];
  logic [PERIOD_W-1:0]   r_bcnt;
  logic                  r_phase;
  logic [PWM_W-1:0]      r_pcnt;
  logic [NUM_LEDS-1:0]   r_led;

  logic                  w_wr_static;
  logic                  w_wr_mode;
  logic                  w_wr_period;
  logic                  w_duty_hit;
  logic                  w_wr_duty;
  logic                  w_bterm;
  logic [NUM_LEDS-1:0]   w_led_next;

  assign w_wr_static = write_en && (address == 4'h0);
  assign w_wr_mode   = write_en && (address == 4'h1);
  assign w_wr_period = write_en && (address == 4'h2);
  assign w_duty_hit  = address[3] && (int'(address[2:0]) < NUM_LEDS);
  assign w_wr_duty   = write_en && w_duty_hit;
  assign w_bterm     = (r_bcnt == r_period);

  // Register file
  always_ff @(posedge clk) begin
    if (rst) begin
      r_static <= '1;
      r_mode   <= '0;
      r_period <= '0;
      for (int ch = 0; ch < NUM_LEDS; ch++) r_duty[ch] <= '0;
    end else begin
      if (w_wr_static) r_static <= data_in[NUM_LEDS-1:0];
      if (w_wr_mode)   r_mode   <= data_in[2*NUM_LEDS-1:0];
      if (w_wr_period) r_period <= data_in[PERIOD_W-1:0];
      for (int ch = 0; ch < NUM_LEDS; ch++) begin
        if (w_wr_duty && (int'(address[2:0]) == ch)) r_duty[ch] <= data_in[PWM_W-1:0];
      end
    end
  end

  // Shared blink and PWM timebases; a PERIOD write restarts the blink half-period with phase high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
      r_pcnt  <= '0;
    end else begin
      r_pcnt <= r_pcnt + PWM_W'(1);
      if (w_wr_period) begin
        r_bcnt  <= '0;
        r_phase <= 1'b1;
      end else if (w_bterm) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt  <= r_bcnt + PERIOD_W'(1);
      end
    end
  end

  always_comb begin
    w_led_next = '0;
    for (int ch = 0; ch < NUM_LEDS; ch++) begin
      case (r_mode[2*ch +: 2])
        2'b00:   w_led_next[ch] = r_static[ch];
        2'b01:   w_led_next[ch] = r_phase;
        2'b10:   w_led_next[ch] = (r_pcnt < r_duty[ch]);
        default: w_led_next[ch] = 1'b0;
      endcase
    end
  end

  // LED output register
  always_ff @(posedge clk) begin
    if (rst) r_led <= '1;
    else     r_led <= w_led_next;
  end

  assign led = r_led;

  always_comb begin
    data_out = '0;
    if (read_en) begin
      case (address)
        4'h0:    data_out[NUM_LEDS-1:0]   = r_static;
        4'h1:    data_out[2*NUM_LEDS-1:0] = r_mode;
        4'h2:    data_out[PERIOD_W-1:0]   = r_period;
        4'h3:    data_out[NUM_LEDS-1:0]   = r_led;
        default: begin
          for (int ch = 0; ch < NUM_LEDS; ch++) begin
            if (w_duty_hit && (int'(address[2:0]) == ch)) data_out[PWM_W-1:0] = r_duty[ch];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bank.sv
// Bench for led_bank: a time-based reference model checked every cycle, plus directed literal checks.
module tb_led_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  address;
  logic        write_en;
  logic        read_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  led;

  int n_chk  = 0;
  int n_pass = 0;

  led_bank #(.NUM_LEDS(4), .PERIOD_W(24), .PWM_W(8)) dut (
    .clk(clk), .rst(rst), .address(address), .write_en(write_en),
    .read_en(read_en), .data_in(data_in), .data_out(data_out), .led(led)
  );

  always #5 clk = ~clk;

  // Reference model: register images plus elapsed-cycle counts since reset (k) and since the
  // blink timebase was last restarted (m); phase and PWM count follow from plain arithmetic.
  logic        m_valid = 1'b0;
  logic [3:0]  m_static;
  logic [7:0]  m_mode;
  logic [23:0] m_per;
  logic [7:0]  m_duty [4];
  logic [3:0]  m_led;
  int          k;
  int          m;

  function automatic logic m_phase();
    return 1'b1 ^ logic'((m / (int'(m_per) + 1)) % 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'h0: return {28'h0, m_static};
      4'h1: return {24'h0, m_mode};
      4'h2: return {8'h0, m_per};
      4'h3: return {28'h0, m_led};
      4'h8, 4'h9, 4'hA, 4'hB: return {24'h0, m_duty[a[1:0]]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] nxt;
    if (rst) begin
      m_valid  = 1'b1;
      m_static = 4'hF;
      m_mode   = 8'h0;
      m_per    = 24'h0;
      for (int i = 0; i < 4; i++) m_duty[i] = 8'h0;
      m_led    = 4'hF;
      k = 0;
      m = 0;
    end else if (m_valid) begin
      for (int ch = 0; ch < 4; ch++) begin
        case (m_mode[2*ch +: 2])
          2'b00:   nxt[ch] = m_static[ch];
          2'b01:   nxt[ch] = m_phase();
          2'b10:   nxt[ch] = ((k % 256) < int'(m_duty[ch]));
          default: nxt[ch] = 1'b0;
        endcase
      end
      m_led = nxt;
      k++;
      m++;
      if (write_en) begin
        case (address)
          4'h0: m_static = data_in[3:0];
          4'h1: m_mode   = data_in[7:0];
          4'h2: begin m_per = data_in[23:0]; m = 0; end
          4'h8, 4'h9, 4'hA, 4'hB: m_duty[address[1:0]] = data_in[7:0];
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_led", {28'h0, led}, {28'h0, m_led});
      check("model_rdata", data_out, read_en ? m_read(address) : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address  = a;
    data_in  = d;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [3:0] a, input logic [31:0] exp);
    address = a;
    read_en = 1'b1;
    #1;
    check(name, data_out, exp);
  endtask

  task automatic count_hi(output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      hi += int'(led[1]);
    end
  endtask

  initial begin
    int hi;
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; address = 4'h0; data_in = 32'h0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    // Reset state
    check("rst_led", {28'h0, led}, 32'hF);
    chk_rd("rst_static", 4'h0, 32'hF);
    chk_rd("rst_mode", 4'h1, 32'h0);
    chk_rd("rst_period", 4'h2, 32'h0);
    chk_rd("rst_ledstat", 4'h3, 32'hF);

    // Static writes and latency
    wr(4'h0, 32'h5);
    check("static_lat_n", {28'h0, led}, 32'hF);
    tick();
    check("static_lat_n1", {28'h0, led}, 32'h5);
    chk_rd("ledstat_5", 4'h3, 32'h5);
    wr(4'h0, 32'hFFFF_FFF0);
    chk_rd("static_mask", 4'h0, 32'h0);

    // Blink on ch0, PERIOD=3
    wr(4'h0, 32'hA);
    wr(4'h1, 32'h1);
    wr(4'h2, 32'h3);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("blink_%0d", i), {31'h0, led[0]}, (i <= 4) ? 32'h1 : 32'h0);
    end
    check("blink_static", {29'h0, led[3:1]}, 32'h5);
    repeat (5) tick();
    wr(4'h2, 32'h3);
    check("blink_rw_0", {31'h0, led[0]}, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("blink_rw_%0d", i), {31'h0, led[0]}, (i <= 4) ? 32'h1 : 32'h0);
    end

    // PWM on ch1
    wr(4'h0, 32'hF);
    wr(4'h1, 32'h8);
    wr(4'h9, 32'd64);
    tick();
    count_hi(hi);
    check("pwm_64", hi, 64);
    check("pwm_others", {28'h0, led & 4'b1101}, 32'hD);
    wr(4'h9, 32'd0);
    tick();
    count_hi(hi);
    check("pwm_0", hi, 0);
    wr(4'h9, 32'd255);
    tick();
    count_hi(hi);
    check("pwm_255", hi, 255);
    chk_rd("duty1", 4'h9, 32'hFF);

    // Forced off and unmapped/read-only writes
    wr(4'h1, 32'hC0);
    tick();
    check("forced_off", {28'h0, led}, 32'h7);
    wr(4'h3, 32'h0);
    for (int a = 12; a < 16; a++) wr(4'(a), 32'hFFFF_FFFF);
    chk_rd("unm_static", 4'h0, 32'hF);
    chk_rd("unm_mode", 4'h1, 32'hC0);
    chk_rd("unm_ledstat", 4'h3, 32'h7);
    for (int a = 12; a < 16; a++) chk_rd($sformatf("unm_rd_%0d", a), 4'(a), 32'h0);
    chk_rd("unm_rd_4", 4'h4, 32'h0);
    read_en = 1'b0;
    #1;
    check("no_read_en", data_out, 32'h0);

    // Reset during activity with a coincident write
    wr(4'h1, 32'h9);
    wr(4'h2, 32'h1);
    wr(4'h9, 32'd100);
    repeat (7) tick();
    rst = 1'b1; write_en = 1'b1; address = 4'h0; data_in = 32'h0;
    tick();
    rst = 1'b0; write_en = 1'b0;
    check("mid_rst_led", {28'h0, led}, 32'hF);
    chk_rd("mid_rst_static", 4'h0, 32'hF);
    chk_rd("mid_rst_mode", 4'h1, 32'h0);
    chk_rd("mid_rst_period", 4'h2, 32'h0);
    chk_rd("mid_rst_duty", 4'h9, 32'h0);
    tick();
    check("mid_rst_led2", {28'h0, led}, 32'hF);
    read_en = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
